chip8_sprite_draw: RTL
======================

# chip8_sprite_draw

CHIP-8 `DXYN` sprite engine: the write-side client of the 256-byte dual-port display RAM. It fetches N sprite bytes from main memory starting at I, XORs each onto the 64×32 framebuffer through one display-RAM port by read-modify-write, and reports collision (VF). It sits between the CPU execute stage and display-RAM port A; port B stays with video scanout.

## Interface
Parameters:
- `MEM_AW`, 12: main-memory address width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle draw request; ignored while `busy`.
- `x` in 8: VX; only `x[5:0]` used.
- `y` in 8: VY; only `y[4:0]` used.
- `n` in 4: sprite height in rows, 0..15.
- `i_base` in MEM_AW: sprite base address I.
- `mem_addr` out MEM_AW: sprite-byte read address.
- `mem_q` in 8: main-memory data, valid one cycle after `mem_addr`.
- `disp_addr` out 8: display-RAM address.
- `disp_d` out 8: display-RAM write data.
- `disp_we` out 1: display-RAM write enable.
- `disp_q` in 8: display-RAM data, valid one cycle after `disp_addr`.
- `busy` out 1: high from the cycle after accepted `start` through DONE.
- `done` out 1: one-cycle completion pulse.
- `collision` out 1: VF result; valid at `done`, held until the next accepted `start`.

## Operation
- Framebuffer layout: byte address = `row*8 + col[5:3]`; bit 7 = leftmost pixel (`col[2:0]==0`).
- On accepted `start`: latch `xs=x[5:0]`, `ys=y[4:0]`, `n`, `i_base`; clear `row` and `collision`; go to FETCH (n≠0) or DONE (n==0).
- Row shift: `{hi,lo} = {sprite,8'h00} >> xs[2:0]` (16-bit logical shift). Left byte at column `xs[5:3]`; right byte at column `xs[5:3]+1`.
- Screen row = `ys+row` (6-bit sum).
- States:
  - IDLE: no memory activity.
  - FETCH: `mem_addr = i_base+row`, modulo 2^MEM_AW.
  - RDL: latch `mem_q`; `disp_addr` = left-byte address.
  - WRL: `disp_d = disp_q ^ hi`; `disp_we = 1`; `collision |= |(disp_q & hi)`. Goes to RDR if `lo≠0` and the right byte exists; else ADV.
  - RDR: `disp_addr` = right-byte address.
  - WRR: `disp_d = disp_q ^ lo`; `disp_we = 1`; collision update as in WRL.
  - ADV (combinational decision inside WRL/WRR, not a separate cycle): `row++`. Go to DONE if `row==n` or the next screen row is off-screen; else FETCH.
  - DONE: `done = 1`, `busy = 1`; next state IDLE.
- `hi==0` still writes, with data unchanged.
- Reset (any time, including mid-draw): state IDLE; `busy`, `done`, `collision`, `disp_we` = 0; `mem_addr`, `disp_addr`, `disp_d` = 0. A partially drawn sprite stays in RAM.

## Timing
- `start` sampled at edge 0. FETCH occupies cycle 1.
- Per row: 3 cycles if the right byte is skipped, 5 cycles otherwise.
- `done` cycle = 1 + sum of row cycles. For n==0, `done` is in cycle 1.
- `disp_we` is high only in WRL/WRR, exactly one cycle per byte written.
- `disp_addr` in each write cycle equals the address read in the preceding cycle.
- The engine never issues a read and a write in the same cycle.

## Configuration
- `SPRITE_WRAP_EN` defined:
  - Screen row = `(ys+row) & 31`; rows never go off-screen.
  - Right-byte column = `(xs[5:3]+1) & 7`, which wraps to the same row's column 0.
- `SPRITE_WRAP_EN` undefined (COSMAC clipping):
  - The draw ends after the last row with `ys+row ≤ 31`.
  - The right byte is skipped when `xs[5:3]==7`.
- In both modes, start coordinates always wrap modulo 64/32.

## Test plan
- Aligned draw, single row:
  - Stimulus: x=0, y=0, n=1, mem[I]=8'hF0, RAM zero.
  - Required: one write, addr 0, data F0; `collision = 0`; `done` in cycle 4.
- Unaligned draw, single row:
  - Stimulus: x=3, y=2, n=1, byte FF.
  - Required: writes addr 16 ← 1F, then addr 17 ← E0; `done` in cycle 6.
- Collision:
  - Stimulus: repeat the previous draw.
  - Required: both bytes return to 00; `collision = 1`.
- Edge wrap/clip:
  - Stimulus: x=60, y=31, n=2, bytes FF, FF.
  - Required with `SPRITE_WRAP_EN`: writes 255 ← 0F, 248 ← F0, 7 ← 0F, 0 ← F0.
  - Required without: single write 255 ← 0F; `done` in cycle 4.
- n==0 and busy handling:
  - Stimulus: `start` with n=0, then `start` asserted during a busy draw.
  - Required: n==0 gives `done` in cycle 1 with no writes; the start during busy is ignored.
- Reset mid-draw:
  - Stimulus: assert `reset` in the WRR cycle.
  - Required: all outputs 0 immediately; a following `start` behaves normally.

Source files
------------

// File: rtl/chip8_sprite_draw_if.sv
// rtl/chip8_sprite_draw_if.sv - command, main-memory and display-RAM signals of the DXYN sprite engine
interface chip8_sprite_draw_if #(
  parameter int MEM_AW = 12
);
  // draw command from the execute stage
  logic              start;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [3:0]        n;
  logic [MEM_AW-1:0] i_base;

  // main-memory read port (sprite bytes)
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_q;

  // display-RAM port A (read-modify-write)
  logic [7:0]        disp_addr;
  logic [7:0]        disp_d;
  logic              disp_we;
  logic [7:0]        disp_q;

  // status back to the execute stage
  logic              busy;
  logic              done;
  logic              collision;

  modport master (
    output start, x, y, n, i_base, mem_q, disp_q,
    input  mem_addr, disp_addr, disp_d, disp_we, busy, done, collision
  );

  modport slave (
    input  start, x, y, n, i_base, mem_q, disp_q,
    output mem_addr, disp_addr, disp_d, disp_we, busy, done, collision
  );
endinterface

// File: rtl/chip8_sprite_draw.sv
// rtl/chip8_sprite_draw.sv - CHIP-8 DXYN sprite engine; define SPRITE_WRAP_EN for wrap-around instead of COSMAC clipping
module chip8_sprite_draw #(
  parameter int MEM_AW = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  chip8_sprite_draw_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RDL,
    S_WRL,
    S_RDR,
    S_WRR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        xs_q, xs_d;
  logic [4:0]        ys_q, ys_d;
  logic [3:0]        n_q, n_d;
  logic [MEM_AW-1:0] ibase_q, ibase_d;
  logic [3:0]        row_q, row_d;
  logic [7:0]        sprite_q, sprite_d;
  logic              collision_q, collision_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              disp_we_q, disp_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        disp_addr_q, disp_addr_d;

  // Sprite row spread across two framebuffer bytes by the pixel offset
  logic [15:0] shifted;
  logic [7:0]  hi;
  logic [7:0]  lo;
  assign shifted = {sprite_q, 8'h00} >> xs_q[2:0];
  assign hi      = shifted[15:8];
  assign lo      = shifted[7:0];

  // Current and next screen rows; bit 5 flags a row below the screen
  logic [4:0] next_row;
  logic [5:0] scr_row;
  logic [5:0] next_scr;
  logic [2:0] rcol;
  logic [7:0] left_addr;
  logic [7:0] right_addr;
  assign next_row   = {1'b0, row_q} + 5'd1;
  assign scr_row    = {1'b0, ys_q} + {2'b00, row_q};
  assign next_scr   = {1'b0, ys_q} + {1'b0, next_row};
  assign rcol       = xs_q[5:3] + 3'd1;
  assign left_addr  = {scr_row[4:0], xs_q[5:3]};
  assign right_addr = {scr_row[4:0], rcol};

  logic right_exists;
  logic next_off;
  logic unused_bits;
`ifdef SPRITE_WRAP_EN
  // Right byte wraps to column 0 of the same row; rows wrap top to bottom
  assign right_exists = 1'b1;
  assign next_off     = 1'b0;
  assign unused_bits  = ^{bus.x[7:6], bus.y[7:5], scr_row[5], next_scr};
`else
  // Clipping: nothing right of column 7, nothing below row 31
  assign right_exists = (xs_q[5:3] != 3'd7);
  assign next_off     = next_scr[5];
  assign unused_bits  = ^{bus.x[7:6], bus.y[7:5], scr_row[5]};
`endif

  // Next-state and registered-output computation for the draw sequence
  always_comb begin
    logic adv;
    adv           = 1'b0;
    state_d       = state_q;
    xs_d          = xs_q;
    ys_d          = ys_q;
    n_d           = n_q;
    ibase_d       = ibase_q;
    row_d         = row_q;
    sprite_d      = sprite_q;
    collision_d   = collision_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    disp_we_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    disp_addr_d   = disp_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          xs_d        = bus.x[5:0];
          ys_d        = bus.y[4:0];
          n_d         = bus.n;
          ibase_d     = bus.i_base;
          row_d       = 4'd0;
          collision_d = 1'b0;
          busy_d      = 1'b1;
          if (bus.n == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_FETCH;
            mem_addr_d = bus.i_base;
          end
        end
      end
      S_FETCH: begin
        state_d     = S_RDL;
        disp_addr_d = left_addr;
      end
      S_RDL: begin
        sprite_d  = bus.mem_q;
        state_d   = S_WRL;
        disp_we_d = 1'b1;
      end
      S_WRL: begin
        collision_d = collision_q | (|(bus.disp_q & hi));
        if ((lo != 8'h00) && right_exists) begin
          state_d     = S_RDR;
          disp_addr_d = right_addr;
        end else begin
          adv = 1'b1;
        end
      end
      S_RDR: begin
        state_d   = S_WRR;
        disp_we_d = 1'b1;
      end
      S_WRR: begin
        collision_d = collision_q | (|(bus.disp_q & lo));
        adv         = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Row advance shared by both write states
    if (adv) begin
      row_d = next_row[3:0];
      if ((next_row == {1'b0, n_q}) || next_off) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d    = S_FETCH;
        mem_addr_d = ibase_q + MEM_AW'(next_row);
      end
    end
  end

  // State and output registers; reset abandons any draw in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      xs_q        <= '0;
      ys_q        <= '0;
      n_q         <= '0;
      ibase_q     <= '0;
      row_q       <= '0;
      sprite_q    <= '0;
      collision_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      disp_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      disp_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      n_q         <= n_d;
      ibase_q     <= ibase_d;
      row_q       <= row_d;
      sprite_q    <= sprite_d;
      collision_q <= collision_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      disp_we_q   <= disp_we_d;
      mem_addr_q  <= mem_addr_d;
      disp_addr_q <= disp_addr_d;
    end
  end

  // Write data follows the RAM read data arriving in the write cycle itself
  always_comb begin
    bus.disp_d = 8'h00;
    if (state_q == S_WRL) begin
      bus.disp_d = bus.disp_q ^ hi;
    end else if (state_q == S_WRR) begin
      bus.disp_d = bus.disp_q ^ lo;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.disp_addr = disp_addr_q;
  assign bus.disp_we   = disp_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.collision = collision_q;

endmodule
